// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one entry, waits for the data response it
// is owed, aligns load data and drives the writeback and forwarding buses.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        pms_valid,
  input  logic        pms_req_ok,
  input  logic        pms_res_from_mem,
  input  logic        pms_res_to_mem,
  input  logic [2:0]  pms_load_type,
  input  logic [1:0]  pms_paddr_lo,
  input  logic        pms_rf_we,
  input  logic [4:0]  pms_dest,
  input  logic [31:0] pms_result,
  input  logic [31:0] pms_pc,
  input  logic        pms_ex,
  output logic        ms_allowin,
  input  logic        flush,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic        ms_rf_we,
  output logic [4:0]  ms_dest,
  output logic [31:0] ms_result,
  output logic [31:0] ms_pc,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        fwd_pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  function automatic logic [31:0] align_load(input logic [2:0]  lt,
                                             input logic [1:0]  lo,
                                             input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b   = raw[{lo, 3'b000} +: 8];
    h   = lo[1] ? raw[31:16] : raw[15:0];
    ext = '0;
    case (lt)
      LD_LB:   ext = 32'(b);
      LD_LBU:  ext = {24'd0, b};
      LD_LH:   ext = 32'(h);
      LD_LHU:  ext = {16'd0, h};
      LD_LW:   ext = raw;
      default: ext = raw;
    endcase
    return ext;
  endfunction

  state_t      state_q, state_d;
  logic        ms_valid_q, ms_valid_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic        load_q, load_d;
  logic        store_q, store_d;
  logic [2:0]  load_type_q, load_type_d;
  logic [1:0]  paddr_lo_q, paddr_lo_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] result_q, result_d;
  logic [31:0] pc_q, pc_d;
  logic        ex_q, ex_d;

  logic        ms_ready_go;
  logic        accept;
  logic        new_wait;
  logic [31:0] raw_data;

  always_comb begin
    ms_ready_go = 1'b0;
    case (state_q)
      S_IDLE:  ms_ready_go = 1'b1;
      S_WAIT:  ms_ready_go = data_ok;
      S_HOLD:  ms_ready_go = 1'b1;
      S_DROP:  ms_ready_go = 1'b0;
      default: ms_ready_go = 1'b0;
    endcase
    ms_allowin = (state_q != S_DROP) && (!ms_valid_q || (ms_ready_go && ws_allowin));
    // A flushed cycle never takes a new entry: upstream is being squashed too.
    accept   = pms_valid && ms_allowin && !flush;
    new_wait = accept && pms_req_ok;
  end

  always_comb begin
    state_d     = state_q;
    rdata_buf_d = rdata_buf_q;
    case (state_q)
      S_IDLE: begin
        if (new_wait) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = data_ok ? S_IDLE : S_DROP;
        end else if (data_ok) begin
          if (ws_allowin) begin
            state_d = new_wait ? S_WAIT : S_IDLE;
          end else begin
            state_d     = S_HOLD;
            rdata_buf_d = data_rdata;
          end
        end
      end
      S_HOLD: begin
        if (flush) state_d = S_IDLE;
        else if (ws_allowin) state_d = new_wait ? S_WAIT : S_IDLE;
      end
      S_DROP: begin
        if (data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ms_valid_d  = flush ? 1'b0 : (ms_allowin ? accept : ms_valid_q);
    load_d      = load_q;
    store_d     = store_q;
    load_type_d = load_type_q;
    paddr_lo_d  = paddr_lo_q;
    rf_we_d     = rf_we_q;
    dest_d      = dest_q;
    result_d    = result_q;
    pc_d        = pc_q;
    ex_d        = ex_q;
    if (accept) begin
      load_d      = pms_res_from_mem;
      store_d     = pms_res_to_mem;
      load_type_d = pms_load_type;
      paddr_lo_d  = pms_paddr_lo;
      rf_we_d     = pms_rf_we;
      dest_d      = pms_dest;
      result_d    = pms_result;
      pc_d        = pms_pc;
      ex_d        = pms_ex;
    end
  end

  // Entry fields are cleared too so the forward bus reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ms_valid_q  <= 1'b0;
      rdata_buf_q <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      load_type_q <= '0;
      paddr_lo_q  <= '0;
      rf_we_q     <= 1'b0;
      dest_q      <= '0;
      result_q    <= '0;
      pc_q        <= '0;
      ex_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_valid_q  <= ms_valid_d;
      rdata_buf_q <= rdata_buf_d;
      load_q      <= load_d;
      store_q     <= store_d;
      load_type_q <= load_type_d;
      paddr_lo_q  <= paddr_lo_d;
      rf_we_q     <= rf_we_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
      pc_q        <= pc_d;
      ex_q        <= ex_d;
    end
  end

  always_comb begin
    raw_data       = (state_q == S_HOLD) ? rdata_buf_q : data_rdata;
    ms_result      = load_q ? align_load(load_type_q, paddr_lo_q, raw_data) : result_q;
    ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
    ms_rf_we       = rf_we_q && ms_valid_q && !ex_q && !store_q;
    ms_dest        = dest_q;
    ms_pc          = pc_q;
    fwd_dest       = dest_q & {5{ms_valid_q && rf_we_q}};
    fwd_data       = ms_result;
    fwd_pending    = ms_valid_q && load_q && (state_q == S_WAIT) && !data_ok;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load alignment, hold, flush/drop,
// back-to-back loads, exceptions, stores and asynchronous reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        pms_valid, pms_req_ok, pms_res_from_mem, pms_res_to_mem;
  logic [2:0]  pms_load_type;
  logic [1:0]  pms_paddr_lo;
  logic        pms_rf_we;
  logic [4:0]  pms_dest;
  logic [31:0] pms_result, pms_pc;
  logic        pms_ex;
  logic        ms_allowin;
  logic        flush, data_ok;
  logic [31:0] data_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid, ms_rf_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result, ms_pc;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_pending;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .pms_valid(pms_valid), .pms_req_ok(pms_req_ok),
    .pms_res_from_mem(pms_res_from_mem), .pms_res_to_mem(pms_res_to_mem),
    .pms_load_type(pms_load_type), .pms_paddr_lo(pms_paddr_lo),
    .pms_rf_we(pms_rf_we), .pms_dest(pms_dest), .pms_result(pms_result),
    .pms_pc(pms_pc), .pms_ex(pms_ex), .ms_allowin(ms_allowin),
    .flush(flush), .data_ok(data_ok), .data_rdata(data_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_rf_we(ms_rf_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_pc(ms_pc), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pms_valid = 0; pms_req_ok = 0; pms_res_from_mem = 0; pms_res_to_mem = 0;
    pms_load_type = 0; pms_paddr_lo = 0; pms_rf_we = 0; pms_dest = 0;
    pms_result = 0; pms_pc = 0; pms_ex = 0;
    flush = 0; data_ok = 0; data_rdata = 0; ws_allowin = 1;
  endtask

  task automatic put_load(input logic [2:0] lt, input logic [1:0] lo,
                          input logic [4:0] dst, input logic [31:0] pc);
    pms_valid = 1; pms_req_ok = 1; pms_res_from_mem = 1; pms_res_to_mem = 0;
    pms_load_type = lt; pms_paddr_lo = lo; pms_rf_we = 1; pms_dest = dst;
    pms_result = 32'h0; pms_pc = pc; pms_ex = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    step();
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin got=%0h exp=1", ms_allowin); end
    total++; if ({fwd_dest, fwd_data, fwd_pending} !== 38'd0) begin bad++; $display("FAIL rst_fwd got=%h exp=0", {fwd_dest, fwd_data, fwd_pending}); end
    reset = 1;
    step();
  endtask

  task automatic test_lb_wait();
    put_load(3'd1, 2'd3, 5'd5, 32'h100);
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL lb_allowin got=%0h exp=1", ms_allowin); end
    step();
    idle_inputs();
    total++; if (fwd_pending !== 1'b1) begin bad++; $display("FAIL lb_pend1 got=%0h exp=1", fwd_pending); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL lb_novalid got=%0h exp=0", ms_to_ws_valid); end
    total++; if (fwd_dest !== 5'd5) begin bad++; $display("FAIL lb_fwd_dest got=%0h exp=5", fwd_dest); end
    step();
    total++; if (fwd_pending !== 1'b1) begin bad++; $display("FAIL lb_pend2 got=%0h exp=1", fwd_pending); end
    step();
    data_ok = 1; data_rdata = 32'h80FF_0000;
    #1;
    total++; if (fwd_pending !== 1'b0) begin bad++; $display("FAIL lb_pend3 got=%0h exp=0", fwd_pending); end
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL lb_valid got=%0h exp=1", ms_to_ws_valid); end
    total++; if (ms_result !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h exp=ffffff80", ms_result); end
    total++; if (fwd_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_fwd_data got=%h exp=ffffff80", fwd_data); end
    total++; if (ms_rf_we !== 1'b1) begin bad++; $display("FAIL lb_rf_we got=%0h exp=1", ms_rf_we); end
    step();
    idle_inputs();
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL lb_once got=%0h exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_lhu_hold();
    put_load(3'd4, 2'd2, 5'd7, 32'h140);
    step();
    idle_inputs();
    data_ok = 1; data_rdata = 32'h8001_1234; ws_allowin = 0;
    step();
    data_ok = 0; data_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0h exp=1", ms_to_ws_valid); end
    total++; if (ms_result !== 32'h0000_8001) begin bad++; $display("FAIL hold_result got=%h exp=00008001", ms_result); end
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL hold_allowin got=%0h exp=0", ms_allowin); end
    total++; if (fwd_pending !== 1'b0) begin bad++; $display("FAIL hold_pend got=%0h exp=0", fwd_pending); end
    step();
    ws_allowin = 1;
    #1;
    total++; if (ms_result !== 32'h0000_8001) begin bad++; $display("FAIL hold_rel_result got=%h exp=00008001", ms_result); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL hold_rel_allowin got=%0h exp=1", ms_allowin); end
    step();
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL hold_idle got=%0h exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_drop();
    put_load(3'd0, 2'd0, 5'd3, 32'h180);
    step();
    idle_inputs();
    flush = 1;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h exp=0", ms_to_ws_valid); end
    step();
    flush = 0;
    #1;
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL drop_allowin1 got=%0h exp=0", ms_allowin); end
    total++; if (fwd_pending !== 1'b0) begin bad++; $display("FAIL drop_pend got=%0h exp=0", fwd_pending); end
    step();
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL drop_allowin2 got=%0h exp=0", ms_allowin); end
    step();
    data_ok = 1; data_rdata = 32'h5555_AAAA;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL drop_dok_valid got=%0h exp=0", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL drop_dok_allowin got=%0h exp=0", ms_allowin); end
    step();
    data_ok = 0;
    #1;
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL drop_idle_allowin got=%0h exp=1", ms_allowin); end
    pms_valid = 1; pms_rf_we = 1; pms_dest = 5'd4; pms_result = 32'h0000_1234; pms_pc = 32'h190;
    step();
    idle_inputs();
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL drop_after_valid got=%0h exp=1", ms_to_ws_valid); end
    total++; if (ms_result !== 32'h0000_1234) begin bad++; $display("FAIL drop_after_result got=%h exp=00001234", ms_result); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0001;
    vals[2] = 32'h3333_0002; vals[3] = 32'h4444_0003;
    put_load(3'd0, 2'd0, 5'd10, 32'h200);
    step();
    for (int k = 1; k <= 4; k++) begin
      data_ok = 1; data_rdata = vals[k-1];
      if (k < 4) put_load(3'd0, 2'd0, 5'(10 + k), 32'h200 + 32'(4 * k));
      else pms_valid = 0;
      #1;
      total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%0h exp=1", k, ms_to_ws_valid); end
      total++; if (ms_result !== vals[k-1]) begin bad++; $display("FAIL b2b_result%0d got=%h exp=%h", k, ms_result, vals[k-1]); end
      total++; if (ms_pc !== 32'h200 + 32'(4 * (k - 1))) begin bad++; $display("FAIL b2b_pc%0d got=%h exp=%h", k, ms_pc, 32'h200 + 32'(4 * (k - 1))); end
      total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL b2b_allowin%0d got=%0h exp=1", k, ms_allowin); end
      step();
    end
    idle_inputs();
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0h exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_align();
    logic [2:0]  lt  [5];
    logic [1:0]  lo  [5];
    logic [31:0] raw [5];
    logic [31:0] exp [5];
    lt[0] = 3'd3; lo[0] = 2'd0; raw[0] = 32'h1234_F00D; exp[0] = 32'hFFFF_F00D;
    lt[1] = 3'd2; lo[1] = 2'd1; raw[1] = 32'h0000_9A00; exp[1] = 32'h0000_009A;
    lt[2] = 3'd0; lo[2] = 2'd0; raw[2] = 32'hCAFE_BABE; exp[2] = 32'hCAFE_BABE;
    lt[3] = 3'd1; lo[3] = 2'd0; raw[3] = 32'hFFFF_FF7F; exp[3] = 32'h0000_007F;
    lt[4] = 3'd3; lo[4] = 2'd2; raw[4] = 32'h7FFF_8000; exp[4] = 32'h0000_7FFF;
    for (int i = 0; i < 5; i++) begin
      put_load(lt[i], lo[i], 5'd20, 32'h300);
      step();
      idle_inputs();
      data_ok = 1; data_rdata = raw[i];
      #1;
      total++; if (ms_result !== exp[i]) begin bad++; $display("FAIL align%0d got=%h exp=%h", i, ms_result, exp[i]); end
      step();
      idle_inputs();
    end
  endtask

  task automatic test_ex();
    pms_valid = 1; pms_req_ok = 0; pms_res_from_mem = 1; pms_ex = 1;
    pms_rf_we = 1; pms_dest = 5'd9; pms_pc = 32'h400;
    step();
    idle_inputs();
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL ex_valid got=%0h exp=1", ms_to_ws_valid); end
    total++; if (ms_rf_we !== 1'b0) begin bad++; $display("FAIL ex_rf_we got=%0h exp=0", ms_rf_we); end
    total++; if (fwd_pending !== 1'b0) begin bad++; $display("FAIL ex_pend got=%0h exp=0", fwd_pending); end
    step();
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL ex_gone got=%0h exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_store();
    pms_valid = 1; pms_req_ok = 1; pms_res_to_mem = 1; pms_rf_we = 0;
    pms_dest = 5'd0; pms_result = 32'h0000_ABCD; pms_pc = 32'h500;
    step();
    idle_inputs();
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL st_wait got=%0h exp=0", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b0) begin bad++; $display("FAIL st_allowin got=%0h exp=0", ms_allowin); end
    step();
    data_ok = 1;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%0h exp=1", ms_to_ws_valid); end
    total++; if (ms_rf_we !== 1'b0) begin bad++; $display("FAIL st_rf_we got=%0h exp=0", ms_rf_we); end
    total++; if (ms_result !== 32'h0000_ABCD) begin bad++; $display("FAIL st_result got=%h exp=0000abcd", ms_result); end
    step();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    put_load(3'd1, 2'd0, 5'd12, 32'h600);
    step();
    idle_inputs();
    data_ok = 1; data_rdata = 32'h0000_007F; ws_allowin = 0;
    step();
    data_ok = 0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL ar_hold got=%0h exp=1", ms_to_ws_valid); end
    #1;
    reset = 0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h exp=0", ms_to_ws_valid); end
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL ar_allowin got=%0h exp=1", ms_allowin); end
    total++; if ({fwd_dest, fwd_data, fwd_pending} !== 38'd0) begin bad++; $display("FAIL ar_fwd got=%h exp=0", {fwd_dest, fwd_data, fwd_pending}); end
    total++; if (ms_result !== 32'd0) begin bad++; $display("FAIL ar_result got=%h exp=0", ms_result); end
    ws_allowin = 1;
    #2;
    reset = 1;
    step();
    total++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL ar_after got=%0h%0h exp=10", ms_allowin, ms_to_ws_valid); end
  endtask

  initial begin
    test_reset();
    test_lb_wait();
    test_lhu_hold();
    test_flush_drop();
    test_back_to_back();
    test_align();
    test_ex();
    test_store();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
